gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_irq_pkg.sv | 20 ++
 rtl/gpio_sync.sv | 44 ++++
 rtl/gpio_irq.sv | 160 ++++++++++++++++
 tb/tb_gpio_irq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg -- shared constants for the GPIO interrupt block.
//   Register word offsets (selected by wb_adr_i[4:2]) and bus widths.
//   Imported by gpio_irq and gpio_sync.
package gpio_irq_pkg;

  localparam int ADR_W = 8;
  localparam int DAT_W = 32;

  typedef logic [2:0] reg_off_t;

  localparam reg_off_t OFF_DATA    = 3'd0;
  localparam reg_off_t OFF_DIR     = 3'd1;
  localparam reg_off_t OFF_SET     = 3'd2;
  localparam reg_off_t OFF_CLR     = 3'd3;
  localparam reg_off_t OFF_RISE_EN = 3'd4;
  localparam reg_off_t OFF_FALL_EN = 3'd5;
  localparam reg_off_t OFF_STAT    = 3'd6;
  localparam reg_off_t OFF_RSVD    = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- per-line input synchroniser plus one "previous" flop used
// for edge detection.
//   wb_clk : clock
//   wb_rst : asynchronous active-high reset, clears every flop
//   pins   : asynchronous pad inputs
//   sync   : pins after SYNC_STAGES flops
//   prev   : sync delayed by one more flop
module gpio_sync
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] prev
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      // Bit 0 is the first (metastable-prone) stage; the top bit is the
      // safe synchronised value.
      logic [SYNC_STAGES-1:0] chain_reg;
      logic                   prev_reg;

      always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
          chain_reg <= '0;
          prev_reg  <= 1'b0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
          prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
      end

      assign sync[gi] = chain_reg[SYNC_STAGES-1];
      assign prev[gi] = prev_reg;
    end
  endgenerate

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq -- Wishbone (classic) GPIO block with per-line rise/fall
// interrupt detection.
//   wb_clk, wb_rst           : clock, asynchronous active-high reset
//   wb_adr_i/dat_i/we_i/...  : Wishbone slave inputs (cti/bte ignored)
//   wb_dat_o, wb_ack_o       : registered read data and ack
//   wb_err_o, wb_rty_o       : always 0
//   gpio_i                   : asynchronous pad inputs
//   gpio_o, gpio_dir_o       : output data and drive enables (1 = drive)
//   irq_o                    : high while any STAT bit is pending
// Register map (word offset): 0 DATA, 1 DIR, 2 SET, 3 CLR, 4 RISE_EN,
// 5 FALL_EN, 6 STAT (W1C), 7 reserved.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [DAT_W-1:0] wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] rise_en_reg, rise_en_next;
  logic [WIDTH-1:0] fall_en_reg, fall_en_next;
  logic [WIDTH-1:0] stat_reg, stat_next;
  logic [WIDTH-1:0] stat_w1c;
  logic [WIDTH-1:0] edge_hit;
  logic             irq_reg;
  logic             ack_reg;
  logic [DAT_W-1:0] dat_reg;
  logic [DAT_W-1:0] rd_word;

  logic             accept;
  logic             in_window;
  reg_off_t         word_sel;
  logic             wr_commit;
  logic [WIDTH-1:0] wdat;

  // Cycle-type tags, byte lanes within a word and data bits above WIDTH
  // carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i};

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .pins   (gpio_i),
    .sync   (sync),
    .prev   (prev)
  );

  // Gating with the ack flop forces a gap cycle between back-to-back acks.
  assign accept    = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign in_window = (wb_adr_i[7:5] == 3'b000);
  assign word_sel  = wb_adr_i[4:2];
  assign wr_commit = accept & wb_we_i & in_window;
  assign wdat      = wb_dat_i[WIDTH-1:0];

  always_comb begin
    out_next     = out_reg;
    dir_next     = dir_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    stat_w1c     = '0;
    if (wr_commit) begin
      case (word_sel)
        OFF_DATA:    out_next     = wdat;
        OFF_DIR:     dir_next     = wdat;
        OFF_SET:     out_next     = out_reg | wdat;
        OFF_CLR:     out_next     = out_reg & ~wdat;
        OFF_RISE_EN: rise_en_next = wdat;
        OFF_FALL_EN: fall_en_next = wdat;
        OFF_STAT:    stat_w1c     = wdat;
        default:     ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      assign edge_hit[gi]  = (sync[gi] & ~prev[gi] & rise_en_reg[gi])
                           | (~sync[gi] & prev[gi] & fall_en_reg[gi]);
      // The OR is applied after the clear so a new event beats a
      // simultaneous W1C of the same bit.
      assign stat_next[gi] = (stat_reg[gi] & ~stat_w1c[gi]) | edge_hit[gi];
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (in_window) begin
      case (word_sel)
        OFF_DATA:    rd_word[WIDTH-1:0] = sync;
        OFF_DIR:     rd_word[WIDTH-1:0] = dir_reg;
        OFF_RISE_EN: rd_word[WIDTH-1:0] = rise_en_reg;
        OFF_FALL_EN: rd_word[WIDTH-1:0] = fall_en_reg;
        OFF_STAT:    rd_word[WIDTH-1:0] = stat_reg;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      out_reg     <= '0;
      dir_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      stat_reg    <= '0;
      irq_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
    end else begin
      out_reg     <= out_next;
      dir_reg     <= dir_next;
      rise_en_reg <= rise_en_next;
      fall_en_reg <= fall_en_next;
      stat_reg    <= stat_next;
      // Registered from stat_next so irq tracks STAT on the same edge
      // while still coming straight off a flop.
      irq_reg     <= |stat_next;
      ack_reg     <= accept;
      if (accept) begin
        dat_reg <= rd_word;
      end
    end
  end

  assign gpio_o     = out_reg;
  assign gpio_dir_o = dir_reg;
  assign irq_o      = irq_reg;
  assign wb_ack_o   = ack_reg;
  assign wb_dat_o   = dat_reg;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_rd;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_dir;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .wb_clk     (clk),
    .wb_rst     (rst),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_w),
    .wb_we_i    (wb_we),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_cti_i   (3'b000),
    .wb_bte_i   (2'b00),
    .wb_dat_o   (wb_dat_rd),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .wb_rty_o   (wb_rty),
    .gpio_i     (gpio_in),
    .gpio_o     (gpio_out),
    .gpio_dir_o (gpio_dir),
    .irq_o      (irq)
  );

  typedef struct {
    logic [7:0]  adr;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_dir;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the ack edge.
  task automatic wb_access(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                           output logic [31:0] rd);
    bit got;
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
    got = 1'b0; rd = '0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_ack) begin
        got = 1'b1;
        rd  = wb_dat_rd;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wb_timeout adr=%h actual=no_ack expected=ack", adr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // adr, we, wdat, exp_rd (reads only), exp_out, exp_dir
    vecs[0]  = '{8'h00, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[1]  = '{8'h04, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[2]  = '{8'h08, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[3]  = '{8'h0C, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[4]  = '{8'h10, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[5]  = '{8'h14, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[6]  = '{8'h18, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[7]  = '{8'h1C, 1'b0, 32'h0,        32'h0,  8'h00, 8'h00};
    vecs[8]  = '{8'h00, 1'b1, 32'hA5,       32'h0,  8'hA5, 8'h00};
    vecs[9]  = '{8'h08, 1'b1, 32'h0F,       32'h0,  8'hAF, 8'h00};
    vecs[10] = '{8'h0C, 1'b1, 32'h81,       32'h0,  8'h2E, 8'h00};
    vecs[11] = '{8'h08, 1'b0, 32'h0,        32'h0,  8'h2E, 8'h00};
    vecs[12] = '{8'h0C, 1'b0, 32'h0,        32'h0,  8'h2E, 8'h00};
    vecs[13] = '{8'h04, 1'b1, 32'hFFFFFF3C, 32'h0,  8'h2E, 8'h3C};
    vecs[14] = '{8'h04, 1'b0, 32'h0,        32'h3C, 8'h2E, 8'h3C};
    vecs[15] = '{8'h1C, 1'b1, 32'hFF,       32'h0,  8'h2E, 8'h3C};
    vecs[16] = '{8'h20, 1'b0, 32'h0,        32'h0,  8'h2E, 8'h3C};
    vecs[17] = '{8'h24, 1'b1, 32'hFF,       32'h0,  8'h2E, 8'h3C};
    vecs[18] = '{8'h04, 1'b0, 32'h0,        32'h3C, 8'h2E, 8'h3C};
    vecs[19] = '{8'h10, 1'b1, 32'hFFFFFF81, 32'h0,  8'h2E, 8'h3C};
    vecs[20] = '{8'h10, 1'b0, 32'h0,        32'h81, 8'h2E, 8'h3C};
    vecs[21] = '{8'h14, 1'b1, 32'h42,       32'h0,  8'h2E, 8'h3C};
    vecs[22] = '{8'h14, 1'b0, 32'h0,        32'h42, 8'h2E, 8'h3C};
    vecs[23] = '{8'h10, 1'b1, 32'h0,        32'h0,  8'h2E, 8'h3C};
    vecs[24] = '{8'h14, 1'b1, 32'h0,        32'h0,  8'h2E, 8'h3C};
    vecs[25] = '{8'h00, 1'b1, 32'hFFFFFF2E, 32'h0,  8'h2E, 8'h3C};
    vecs[26] = '{8'h18, 1'b0, 32'h0,        32'h0,  8'h2E, 8'h3C};

    rst = 1'b1; gpio_in = '0;
    wb_adr = '0; wb_dat_w = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ack", {31'b0, wb_ack}, 32'h0);
    check("reset_dat_o", wb_dat_rd, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("err_rty", {30'b0, wb_err, wb_rty}, 32'h0);

    // Table: reset reads, output ops, masking and out-of-window accesses.
    for (int i = 0; i < NV; i++) begin
      wb_access(vecs[i].adr, vecs[i].we, vecs[i].wdat, rd);
      $display("vec %0d adr=%h we=%0d wdat=%h rd=%h gpio_o=%h dir=%h irq=%0d",
               i, vecs[i].adr, vecs[i].we, vecs[i].wdat, rd, gpio_out, gpio_dir, irq);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_gpio_o", i), {24'b0, gpio_out}, {24'b0, vecs[i].exp_out});
      check($sformatf("vec%0d_dir", i), {24'b0, gpio_dir}, {24'b0, vecs[i].exp_dir});
    end
    check("table_irq", {31'b0, irq}, 32'h0);

    // DATA reads the synchronised pins regardless of DIR.
    gpio_in = 8'h5A;
    repeat (4) @(posedge clk);
    #1;
    wb_access(8'h00, 1'b0, 32'h0, rd);
    $display("data_read pins=5a rd=%h", rd);
    check("data_read_5a", rd, 32'h5A);
    gpio_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    wb_access(8'h00, 1'b0, 32'h0, rd);
    $display("data_read pins=00 rd=%h", rd);
    check("data_read_00", rd, 32'h0);
    check("no_enable_irq", {31'b0, irq}, 32'h0);

    // Rise on bit 0: irq on the third edge that samples the change.
    wb_access(8'h10, 1'b1, 32'h01, rd);
    gpio_in[0] = 1'b1;
    @(posedge clk); #1;
    check("rise_edge1_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("rise_edge2_irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("rise_edge3_irq", {31'b0, irq}, 32'h1);
    $display("rise_seq irq=%0d", irq);
    wb_access(8'h18, 1'b0, 32'h0, rd);
    check("rise_stat", rd, 32'h01);
    wb_access(8'h18, 1'b1, 32'h01, rd);
    $display("w1c stat=01 irq=%0d", irq);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    wb_access(8'h18, 1'b0, 32'h0, rd);
    check("w1c_stat", rd, 32'h0);

    // Clearing an enable keeps the pending bit.
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 gpio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wb_access(8'h10, 1'b1, 32'h00, rd);
    wb_access(8'h18, 1'b0, 32'h0, rd);
    $display("enable_clear stat=%h irq=%0d", rd, irq);
    check("en_clear_stat", rd, 32'h01);
    check("en_clear_irq", {31'b0, irq}, 32'h1);
    wb_access(8'h18, 1'b1, 32'h01, rd);
    check("en_clear_w1c_irq", {31'b0, irq}, 32'h0);

    // Collision: fall on bit 3 sets STAT on the same edge as W1C of bit 3.
    wb_access(8'h14, 1'b1, 32'h08, rd);
    gpio_in[3] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_collision_irq", {31'b0, irq}, 32'h0);
    gpio_in[3] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_adr = 8'h18; wb_dat_w = 32'h08; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    check("collision_ack", {31'b0, wb_ack}, 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_access(8'h18, 1'b0, 32'h0, rd);
    $display("collision stat=%h irq=%0d", rd, irq);
    check("collision_stat", rd, 32'h08);
    check("collision_irq", {31'b0, irq}, 32'h1);

    // Held strobe: ack toggles every other cycle.
    @(posedge clk); #1;
    wb_adr = 8'h04; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    check("held_ack0", {31'b0, wb_ack}, 32'h0);
    for (int c = 1; c < 6; c++) begin
      @(posedge clk); #1;
      $display("held cycle %0d ack=%0d", c, wb_ack);
      check($sformatf("held_ack%0d", c), {31'b0, wb_ack}, (c % 2 == 1) ? 32'h1 : 32'h0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;

    // Reset asserted across the accepting edge of a DIR write.
    wb_adr = 8'h04; wb_dat_w = 32'hFF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    $display("reset_mid_write ack=%0d dir=%h gpio_o=%h irq=%0d", wb_ack, gpio_dir, gpio_out, irq);
    check("rstmid_ack", {31'b0, wb_ack}, 32'h0);
    check("rstmid_dir", {24'b0, gpio_dir}, 32'h0);
    check("rstmid_gpio_o", {24'b0, gpio_out}, 32'h0);
    check("rstmid_irq", {31'b0, irq}, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_ack_after", {31'b0, wb_ack}, 32'h0);
    check("rstmid_dir_after", {24'b0, gpio_dir}, 32'h0);

    // First access after reset release is accepted normally.
    wb_access(8'h04, 1'b1, 32'h11, rd);
    check("post_rst_dir", {24'b0, gpio_dir}, 32'h11);
    wb_access(8'h18, 1'b0, 32'h0, rd);
    $display("post_reset dir=%h stat=%h", gpio_dir, rd);
    check("post_rst_stat", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
